// File: rtl/pwm_dty_ramp.sv
// Slew-rate limiter for a PWM duty command. It ramps dty toward a clamped signed setpoint
// and dwells at zero when the direction reverses. PWM_DTY_RAMP_WDOG_EN enables the setpoint watchdog.
module pwm_dty_ramp #(
  parameter int STEP       = 8,
  parameter int TICK_DIV   = 1000,
  parameter int ZERO_HOLD  = 16,
  parameter int MAX_DTY    = 255,
  parameter int WDOG_TICKS = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] set_dty,
  input  logic               set_valid,
  input  logic               enable,
  output logic signed [31:0] dty,
  output logic               en_out,
  output logic               busy,
  output logic               wdog_trip
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RAMP  = 2'd1;
  localparam logic [1:0] ST_DWELL = 2'd2;

  localparam logic [20:0]        TICK_LAST = 21'(TICK_DIV - 1);
  localparam logic [15:0]        HOLD_LOAD = 16'(ZERO_HOLD);
  localparam logic signed [32:0] LIM_S     = 33'(MAX_DTY);
  localparam logic signed [32:0] STEP_S    = 33'(STEP);

  logic [1:0]         state;
  logic [20:0]        tick_cnt;
  logic [15:0]        dwell_cnt;
  logic signed [31:0] target;
  logic               tick;
  logic               opp_sign;
  logic signed [31:0] dty_step;

  // Saturate a requested duty to the symmetric magnitude limit.
  function automatic logic signed [31:0] sat_dty(input logic signed [31:0] v);
    logic signed [32:0] w;
    w = 33'(v);
    if (w > LIM_S) return 32'(LIM_S);
    if (w < -LIM_S) return 32'(-LIM_S);
    return v;
  endfunction

  // One slew step from 'from' toward 'to'. The 33-bit difference cannot overflow.
  function automatic logic signed [31:0] slew(input logic signed [31:0] from,
                                              input logic signed [31:0] to);
    logic signed [32:0] diff;
    diff = 33'(to) - 33'(from);
    if (diff > STEP_S) return 32'(33'(from) + STEP_S);
    if (diff < -STEP_S) return 32'(33'(from) - STEP_S);
    return to;
  endfunction

  always_comb begin
    tick     = (state != ST_IDLE) && (tick_cnt == TICK_LAST);
    opp_sign = (dty != 32'sd0) && (target != 32'sd0) && (dty[31] != target[31]);
    dty_step = opp_sign ? slew(dty, 32'sd0) : slew(dty, target);
  end

  assign busy = (dty != target) || (state == ST_DWELL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dty       <= '0;
      tick_cnt  <= '0;
      dwell_cnt <= '0;
      en_out    <= 1'b0;
    end else begin
      en_out <= enable;
      if (!enable) begin
        state     <= ST_IDLE;
        dty       <= '0;
        tick_cnt  <= '0;
        dwell_cnt <= '0;
      end else begin
        if (state == ST_IDLE) begin
          state    <= ST_RAMP;
          tick_cnt <= '0;
        end else begin
          tick_cnt <= tick ? 21'd0 : tick_cnt + 21'd1;
        end
        if (tick) begin
          case (state)
            ST_RAMP: begin
              dty <= dty_step;
              // Reaching zero on a reversal starts the dwell unless the hold time is zero.
              if (opp_sign && (dty_step == 32'sd0) && (HOLD_LOAD != 16'd0)) begin
                state     <= ST_DWELL;
                dwell_cnt <= HOLD_LOAD;
              end
            end
            ST_DWELL: begin
              dwell_cnt <= dwell_cnt - 16'd1;
              if (dwell_cnt == 16'd1) state <= ST_RAMP;
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef PWM_DTY_RAMP_WDOG_EN
  localparam logic [31:0] WDOG_LIM  = 32'(WDOG_TICKS);
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_TICKS - 1);

  logic [31:0] sil_cnt;

  // The silence counter saturates at the limit, so the trip fires only once per silence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target    <= '0;
      sil_cnt   <= '0;
      wdog_trip <= 1'b0;
    end else begin
      if (set_valid) target <= sat_dty(set_dty);
      if (!enable) begin
        sil_cnt   <= '0;
        wdog_trip <= 1'b0;
      end else if (set_valid) begin
        sil_cnt <= '0;
      end else if (tick && (sil_cnt != WDOG_LIM)) begin
        sil_cnt <= sil_cnt + 32'd1;
        if (sil_cnt == WDOG_LAST) begin
          target    <= '0;
          wdog_trip <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_wdog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) target <= '0;
    else if (set_valid) target <= sat_dty(set_dty);
  end

  assign wdog_trip   = 1'b0;
  // WDOG_TICKS has no effect in this build.
  assign unused_wdog = (WDOG_TICKS != 0);
`endif

endmodule

// File: doc/pwm_dty_ramp.md
PWM_DTY_RAMP -- requirements
Module: pwm_dty_ramp

Interface
REQ-001 SHALL have parameter STEP, default 8: maximum duty change per update tick, range 1..MAX_DTY.
REQ-002 SHALL have parameter TICK_DIV, default 1000: clocks per update tick, range 1..2^20.
REQ-003 SHALL have parameter ZERO_HOLD, default 16: update ticks to dwell at zero on direction reversal, range 0..2^16-1.
REQ-004 SHALL have parameter MAX_DTY, default 255: magnitude clamp applied to the target.
REQ-005 SHALL have parameter WDOG_TICKS, default 50000: setpoint-silence limit in update ticks; used only when PWM_DTY_RAMP_WDOG_EN is defined.
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 set_dty  in  32 signed  requested duty; sign is direction, magnitude is duty.
REQ-009 set_valid  in  1  one-clock strobe; set_dty is captured as the new target.
REQ-010 enable  in  1  ramp enable.
REQ-011 dty  out  32 signed, registered  slewed duty, fed to the downstream pwm generator.
REQ-012 en_out  out  1, registered  enable, delayed one clock.
REQ-013 busy  out  1  high while dty != target or state is DWELL.
REQ-014 wdog_trip  out  1, registered  sticky watchdog flag.

Function
REQ-015 Target SHALL be set_dty clamped to [-MAX_DTY, +MAX_DTY] when captured; the magnitude of dty SHALL never exceed MAX_DTY.
REQ-016 Tick counter SHALL count 0..TICK_DIV-1 and emit a one-clock tick strobe at TICK_DIV-1, then wrap to 0.
REQ-017 All difference arithmetic SHALL use 33-bit signed values, so no overflow occurs at any input.
REQ-018 States SHALL be IDLE, RAMP and DWELL.
REQ-019 IDLE: dty = 0; tick counter held at 0; go to RAMP on the clock after enable rises.
REQ-020 RAMP, on tick, same-sign or zero case (target and dty of the same sign, or either is 0): dty moves toward target by min(STEP, |target-dty|).
REQ-021 RAMP, on tick, opposite-sign case (target and dty nonzero with opposite signs): dty moves toward 0 by min(STEP, |dty|).
REQ-022 RAMP: when that opposite-sign step lands on 0, SHALL go to DWELL with the dwell counter loaded to ZERO_HOLD.
REQ-023 ZERO_HOLD=0 SHALL skip DWELL; ramping toward the target resumes on the next tick.
REQ-024 DWELL: dty held at 0; dwell counter decrements on each tick; SHALL return to RAMP on the tick where it reaches 0.
REQ-025 DWELL: a target change during the dwell SHALL NOT shorten it.
REQ-026 enable low in any state: the next clock gives dty = 0, state IDLE, dwell counter cleared; there SHALL be no ramp-down.
REQ-027 set_valid coinciding with a tick: the tick SHALL use the old target; the new target takes effect from the next tick.
REQ-028 dty SHALL change only on tick clocks, or on the forced zeroing of REQ-026 and REQ-032.
REQ-029 busy SHALL be combinational from the registered state.

Reset
REQ-030 While rst is high, outputs and state SHALL be held at: dty=0, en_out=0, busy=0, wdog_trip=0, state IDLE, target=0, all counters 0.
REQ-031 rst asserted mid-ramp or mid-dwell SHALL abort immediately with no further output activity; the first tick after release occurs TICK_DIV clocks after enable is seen high.

Configuration
REQ-032 With PWM_DTY_RAMP_WDOG_EN defined: a silence counter SHALL count ticks since the last set_valid while enable is high; on reaching WDOG_TICKS, target forced to 0 (normal ramp-down toward 0, not a jump), wdog_trip set.
REQ-033 With the macro defined, wdog_trip SHALL clear only on rst or on enable low; a set_valid after the trip SHALL restart ramping and the silence counter but SHALL NOT clear wdog_trip.
REQ-034 Without the macro: wdog_trip tied to 0, no silence counter, target persists indefinitely.

Verification (STEP=10, TICK_DIV=4, ZERO_HOLD=2, MAX_DTY=255, WDOG_TICKS=8)
REQ-035 Ramp up: enable=1, set_dty=35 -> dty goes 10, 20, 30, 35 on four successive ticks 4 clocks apart; busy falls with 35.
REQ-036 Reversal: from dty=25, set_dty=-15 -> 15, 5, 0, dwell of 2 ticks at 0, then -10, -15.
REQ-037 Clamp and width: set_dty=32'h8000_0000 -> target -255; dty reaches -255 after 26 ticks with no wrap.
REQ-038 Abort: enable low at dty=20 -> dty=0 and en_out=0 one clock later; rst mid-DWELL -> all outputs 0 asynchronously.
REQ-039 Coincidence: set_valid with 100 on a tick clock while target=30 and dty=20 -> dty=30 on that tick, 40 on the next.
REQ-040 Watchdog (macro defined): at dty=50, no set_valid for 8 ticks -> wdog_trip=1 and dty ramps to 0; macro undefined -> dty stays 50 and wdog_trip=0.
